// File: rtl/game_flow_ctrl.sv
// Game-flow FSM: run/pause/death/level-advance/win sequencing,
// lives, score, level index, lava oscillator and respawn coordinates.
module game_flow_ctrl #(
  parameter int NUM_LEVELS = 4,
  parameter int LEVEL_W = 2,
  parameter int LIVES = 3,
  parameter int SCORE_W = 16,
  parameter int LAVA_TOP = 380,
  parameter int LAVA_STEP = 3,
  parameter logic [(1<<LEVEL_W)-1:0] LAVA_LEVEL_MASK = 4'b0001,
  parameter int RESPAWN_TICKS = 60,
  parameter int SPAWN_X = 20,
  parameter int SPAWN_Y0 = 344,
  parameter int SPAWN_YN = 364
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_tick,
  input  logic               in_lava,
  input  logic               at_goal,
  input  logic               jump_landed,
  input  logic               pause_btn,
  input  logic               restart,
  output logic [2:0]         game_state,
  output logic               freeze,
  output logic [LEVEL_W-1:0] level,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [9:0]         lava_height,
  output logic [9:0]         spawn_x,
  output logic [9:0]         spawn_y,
  output logic               respawn_pulse,
  output logic               lava_boost
);

  localparam int CNT_W = $clog2(RESPAWN_TICKS + 1);

  typedef enum logic [2:0] {
    S_RUN    = 3'd0,
    S_OVER   = 3'd1,
    S_WIN    = 3'd2,
    S_DYING  = 3'd3,
    S_LDONE  = 3'd4,
    S_PAUSED = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [2:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [9:0]         lava_q, lava_d;
  logic               up_q, up_d;
  logic [9:0]         spy_q, spy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pause_q, pause_d;
  logic               rp_q, rp_d;
  logic               lb_q, lb_d;

  logic [10:0]        step;
  logic [10:0]        sum;
  logic [9:0]         lava_nx;
  logic               up_nx;
  logic               pause_edge;

  // Lava oscillator candidate for this tick, 11-bit so nothing wraps
  always_comb begin
    step = 11'(LAVA_STEP) + 11'(level_q);
    sum = {1'b0, lava_q} + step;
    lava_nx = lava_q;
    up_nx = up_q;
    if (!LAVA_LEVEL_MASK[level_q]) begin
      lava_nx = '0;
      up_nx = 1'b1;
    end else if (up_q) begin
      if (sum < 11'(LAVA_TOP)) begin
        lava_nx = sum[9:0];
      end else begin
        lava_nx = 10'(LAVA_TOP);
        up_nx = 1'b0;
      end
    end else begin
      if ({1'b0, lava_q} >= step) begin
        lava_nx = 10'({1'b0, lava_q} - step);
      end else begin
        lava_nx = '0;
        up_nx = 1'b1;
      end
    end
  end

  assign pause_edge = pause_btn & ~pause_q;

  // Next-state and pulse logic; nothing but pulses moves off-tick
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    lives_d = lives_q;
    score_d = score_q;
    lava_d = lava_q;
    up_d = up_q;
    spy_d = spy_q;
    cnt_d = cnt_q;
    pause_d = pause_q;
    rp_d = 1'b0;
    lb_d = 1'b0;
    if (game_tick) begin
      pause_d = pause_btn;
      if (restart) begin
        state_d = S_RUN;
        level_d = '0;
        lives_d = 3'(LIVES);
        score_d = '0;
        lava_d = '0;
        up_d = 1'b1;
        spy_d = 10'(SPAWN_Y0);
        cnt_d = '0;
        rp_d = 1'b1;
      end else begin
        case (state_q)
          S_RUN: begin
            if (jump_landed) begin
              lb_d = 1'b1;
              if (score_q != '1)
                score_d = score_q + SCORE_W'(1);
            end
            lava_d = lava_nx;
            up_d = up_nx;
            if (pause_edge) begin
              state_d = S_PAUSED;
            end else if (in_lava) begin
              lives_d = lives_q - 3'd1;
              lava_d = '0;
              up_d = 1'b1;
              cnt_d = CNT_W'(RESPAWN_TICKS);
              state_d = (lives_q == 3'd1) ? S_OVER : S_DYING;
            end else if (at_goal) begin
              cnt_d = CNT_W'(RESPAWN_TICKS);
              if (level_q == LEVEL_W'(NUM_LEVELS - 1))
                state_d = S_WIN;
              else
                state_d = S_LDONE;
            end
          end
          S_DYING: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d = S_RUN;
              rp_d = 1'b1;
            end
          end
          S_LDONE: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d = S_RUN;
              level_d = level_q + LEVEL_W'(1);
              spy_d = 10'(SPAWN_YN);
              lava_d = '0;
              up_d = 1'b1;
              rp_d = 1'b1;
            end
          end
          S_PAUSED: begin
            if (pause_edge)
              state_d = S_RUN;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      level_q <= '0;
      lives_q <= 3'(LIVES);
      score_q <= '0;
      lava_q <= '0;
      up_q <= 1'b1;
      spy_q <= 10'(SPAWN_Y0);
      cnt_q <= '0;
      pause_q <= 1'b0;
      rp_q <= 1'b0;
      lb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      lives_q <= lives_d;
      score_q <= score_d;
      lava_q <= lava_d;
      up_q <= up_d;
      spy_q <= spy_d;
      cnt_q <= cnt_d;
      pause_q <= pause_d;
      rp_q <= rp_d;
      lb_q <= lb_d;
    end
  end

  assign game_state = state_q;
  assign freeze = (state_q != S_RUN);
  assign level = level_q;
  assign lives = lives_q;
  assign score = score_q;
  assign lava_height = lava_q;
  assign spawn_x = 10'(SPAWN_X);
  assign spawn_y = spy_q;
  assign respawn_pulse = rp_q;
  assign lava_boost = lb_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios then random play,
// all outputs compared against a rule-level game model.
module tb_game_flow_ctrl;

  localparam int SW = 8;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 0;
  logic rst = 0;
  logic game_tick = 0;
  logic in_lava = 0;
  logic at_goal = 0;
  logic jump_landed = 0;
  logic pause_btn = 0;
  logic restart = 0;
  logic [2:0] game_state;
  logic freeze;
  logic [1:0] level;
  logic [2:0] lives;
  logic [SW-1:0] score;
  logic [9:0] lava_height;
  logic [9:0] spawn_x;
  logic [9:0] spawn_y;
  logic respawn_pulse;
  logic lava_boost;

  game_flow_ctrl #(.SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .game_tick(game_tick),
    .in_lava(in_lava), .at_goal(at_goal),
    .jump_landed(jump_landed), .pause_btn(pause_btn),
    .restart(restart), .game_state(game_state),
    .freeze(freeze), .level(level), .lives(lives),
    .score(score), .lava_height(lava_height),
    .spawn_x(spawn_x), .spawn_y(spawn_y),
    .respawn_pulse(respawn_pulse), .lava_boost(lava_boost)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rp_seen = 0;

  // game model: 0 RUN,1 OVER,2 WIN,3 DYING,4 LDONE,5 PAUSED
  int m_st, m_lvl, m_lives, m_score, m_h, m_up;
  int m_sy, m_cd, m_pp, m_rp, m_lb;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_lvl = 0; m_lives = 3; m_score = 0;
    m_h = 0; m_up = 1; m_sy = 344; m_cd = 0;
    m_pp = 0; m_rp = 0; m_lb = 0;
  endtask

  task automatic model_lava();
    int s;
    if (m_lvl != 0) begin
      m_h = 0; m_up = 1;
    end else begin
      s = 3 + m_lvl;
      if (m_up == 1) begin
        if (m_h + s < 380) m_h = m_h + s;
        else begin m_h = 380; m_up = 0; end
      end else begin
        if (m_h >= s) m_h = m_h - s;
        else begin m_h = 0; m_up = 1; end
      end
    end
  endtask

  task automatic model_tick(input bit inl, input bit goal,
                            input bit jl, input bit pb,
                            input bit rs);
    bit pe;
    pe = pb && (m_pp == 0);
    m_pp = pb;
    m_rp = 0; m_lb = 0;
    if (rs) begin
      m_st = 0; m_lvl = 0; m_lives = 3; m_score = 0;
      m_h = 0; m_up = 1; m_sy = 344; m_cd = 0; m_rp = 1;
    end else if (m_st == 0) begin
      if (jl) begin
        m_lb = 1;
        if (m_score < SMAX) m_score++;
      end
      model_lava();
      if (pe) m_st = 5;
      else if (inl) begin
        m_lives--; m_h = 0; m_up = 1; m_cd = 60;
        m_st = (m_lives == 0) ? 1 : 3;
      end else if (goal) begin
        m_cd = 60;
        m_st = (m_lvl == 3) ? 2 : 4;
      end
    end else if (m_st == 3) begin
      if (m_cd == 1) begin m_st = 0; m_rp = 1; end
      m_cd--;
    end else if (m_st == 4) begin
      if (m_cd == 1) begin
        m_st = 0; m_lvl++; m_sy = 364;
        m_h = 0; m_up = 1; m_rp = 1;
      end
      m_cd--;
    end else if (m_st == 5) begin
      if (pe) m_st = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 32'(game_state), 32'(m_st));
    chk({tag, ".freeze"}, 32'(freeze), 32'(m_st != 0));
    chk({tag, ".level"}, 32'(level), 32'(m_lvl));
    chk({tag, ".lives"}, 32'(lives), 32'(m_lives));
    chk({tag, ".score"}, 32'(score), 32'(m_score));
    chk({tag, ".lava"}, 32'(lava_height), 32'(m_h));
    chk({tag, ".spx"}, 32'(spawn_x), 32'd20);
    chk({tag, ".spy"}, 32'(spawn_y), 32'(m_sy));
    chk({tag, ".rp"}, 32'(respawn_pulse), 32'(m_rp));
    chk({tag, ".lb"}, 32'(lava_boost), 32'(m_lb));
  endtask

  task automatic tick(input string tag, input bit inl,
                      input bit goal, input bit jl,
                      input bit pb, input bit rs);
    @(negedge clk);
    in_lava = inl; at_goal = goal; jump_landed = jl;
    pause_btn = pb; restart = rs; game_tick = 1;
    model_tick(inl, goal, jl, pb, rs);
    @(negedge clk);
    game_tick = 0;
    in_lava = 1'($urandom); at_goal = 1'($urandom);
    jump_landed = 1'($urandom); restart = 1'($urandom);
    pause_btn = 1'($urandom);
    if (respawn_pulse) rp_seen++;
    check_all(tag);
    @(negedge clk);
    m_rp = 0; m_lb = 0;
    check_all({tag, ".idle"});
  endtask

  task automatic idle_ticks(input string tag, input int n,
                            input bit pb);
    for (int i = 0; i < n; i++) tick(tag, 0, 0, 0, pb, 0);
  endtask

  initial begin
    int h0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1;

    // T1: lava climbs 3 per tick on level 0
    idle_ticks("t1", 10, 0);
    chk("t1.lava30", 32'(lava_height), 32'd30);

    // T2: death with lives left, timed respawn
    tick("t2", 1, 0, 0, 0, 0);
    chk("t2.dying", 32'(game_state), 32'd3);
    chk("t2.lives", 32'(lives), 32'd2);
    rp_seen = 0;
    idle_ticks("t2w", 60, 0);
    chk("t2.run", 32'(game_state), 32'd0);
    chk("t2.rp_once", 32'(rp_seen), 32'd1);

    // T3: run out of lives, then restart
    tick("t3a", 1, 0, 0, 0, 0);
    idle_ticks("t3w", 60, 0);
    tick("t3b", 1, 0, 0, 0, 0);
    chk("t3.over", 32'(game_state), 32'd1);
    chk("t3.lives0", 32'(lives), 32'd0);
    idle_ticks("t3hold", 5, 0);
    tick("t3r", 0, 0, 0, 0, 1);
    chk("t3.lives3", 32'(lives), 32'd3);

    // T4: goal on level 0 advances to disabled-lava level 1
    idle_ticks("t4pre", 4, 0);
    tick("t4", 0, 1, 0, 0, 0);
    chk("t4.ldone", 32'(game_state), 32'd4);
    idle_ticks("t4w", 60, 0);
    chk("t4.level1", 32'(level), 32'd1);
    chk("t4.spy", 32'(spawn_y), 32'd364);
    idle_ticks("t4post", 5, 0);
    chk("t4.lava0", 32'(lava_height), 32'd0);

    // T5: score saturation
    for (int i = 0; i < SMAX + 4; i++) tick("t5", 0, 0, 1, 0, 0);
    chk("t5.sat", 32'(score), 32'(SMAX));

    // T6: pause beats in_lava; lava resumes on unpause
    tick("t6r", 0, 0, 0, 0, 1);
    idle_ticks("t6pre", 7, 0);
    tick("t6p", 1, 0, 0, 1, 0);
    chk("t6.paused", 32'(game_state), 32'd5);
    chk("t6.lives", 32'(lives), 32'd3);
    h0 = 32'(lava_height);
    tick("t6hold", 1, 1, 1, 1, 0);
    tick("t6low", 1, 0, 0, 0, 0);
    chk("t6.hold", 32'(lava_height), 32'(h0));
    tick("t6u", 0, 0, 0, 1, 0);
    chk("t6.run", 32'(game_state), 32'd0);
    tick("t6c", 0, 0, 0, 1, 0);
    chk("t6.cont", 32'(lava_height), 32'(h0 + 3));

    // async reset in the middle of a death countdown
    tick("ar", 1, 0, 0, 0, 0);
    idle_ticks("arw", 10, 0);
    #2 rst = 0;
    #1 model_reset();
    check_all("areset");
    @(negedge clk);
    rst = 1;

    // random play against the model
    for (int i = 0; i < 2500; i++) begin
      bit rs, inl, goal, jl, pb;
      rs = ($urandom_range(0, 199) == 0) ||
           ((m_st == 1 || m_st == 2) &&
            $urandom_range(0, 9) == 0);
      inl = ($urandom_range(0, 39) == 0);
      goal = ($urandom_range(0, 29) == 0);
      jl = ($urandom_range(0, 2) == 0);
      pb = (m_pp != 0) ? ($urandom_range(0, 9) != 0)
                       : ($urandom_range(0, 24) == 0);
      tick("rand", inl, goal, jl, pb, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
